data_mem_arbiter: RTL and testbench

- Two-master arbiter and sequencer in front of the single-ported data memory.
- Master 0 is the CPU load/store port; master 1 is the secondary master (debug/DMA loader).
- Serialises accesses, generates the one-cycle memread/memwrite strobes the memory expects, absorbs its 2-cycle read timing, and returns registered read data with a one-cycle ack per master.

---
 rtl/data_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter/sequencer in front of the single-ported data memory.
// Define DATA_MEM_ARBITER_FIXED_PRIO_EN for fixed priority (master 0 wins ties).
module data_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MASK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [MASK_WIDTH-1:0] m0_mask,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_stall,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [MASK_WIDTH-1:0] m1_mask,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic [MASK_WIDTH-1:0] mem_sign_mask,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_clk_stall
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRdWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic                  cmd_we_q;
    logic                  cmd_id_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DATA_WIDTH-1:0] cmd_wdata_q;
    logic [MASK_WIDTH-1:0] cmd_mask_q;

    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic                  protocol_err;

    logic                  grant;
    logic                  grant_id;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [MASK_WIDTH-1:0] sel_mask;

`ifdef DATA_MEM_ARBITER_FIXED_PRIO_EN
    always_comb begin
        grant_id = ~m0_req;
    end
`else
    logic last_grant_q;

    // Tie goes to whichever master was not served last.
    always_comb begin
        grant_id = 1'b0;
        if (m0_req && m1_req) begin
            grant_id = ~last_grant_q;
        end else if (m1_req) begin
            grant_id = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (grant) begin
            last_grant_q <= grant_id;
        end
    end
`endif

    assign grant = (state_q == StIdle) && (m0_req || m1_req);

    always_comb begin
        if (grant_id) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_mask  = m1_mask;
        end else begin
            sel_we    = m0_we;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
            sel_mask  = m0_mask;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = cmd_we_q ? StResp : StRdWait;
            end
            StRdWait: begin
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Command register doubles as the memory-side address/data/mask drivers,
    // so those outputs hold their last value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_we_q    <= 1'b0;
            cmd_id_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_mask_q  <= '0;
        end else if (grant) begin
            cmd_we_q    <= sel_we;
            cmd_id_q    <= grant_id;
            cmd_addr_q  <= sel_addr;
            cmd_wdata_q <= sel_wdata;
            cmd_mask_q  <= sel_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == StRdWait) begin
            if (cmd_id_q) begin
                rdata1_q <= mem_read_data;
            end else begin
                rdata0_q <= mem_read_data;
            end
        end
    end

    // The memory must be stalling while its read is in flight; flag it if not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            protocol_err <= 1'b0;
        end else if ((state_q == StRdWait) && !mem_clk_stall) begin
            protocol_err <= 1'b1;
        end
    end

    assign mem_addr      = cmd_addr_q;
    assign mem_wdata     = cmd_wdata_q;
    assign mem_sign_mask = cmd_mask_q;
    assign mem_memread   = (state_q == StIssue) && !cmd_we_q;
    assign mem_memwrite  = (state_q == StIssue) && cmd_we_q;

    assign m0_ack   = (state_q == StResp) && !cmd_id_q;
    assign m1_ack   = (state_q == StResp) && cmd_id_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign m0_stall = m0_req && !m0_ack && !rst;

    strobes_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(mem_memread && mem_memwrite));
    acks_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(m0_ack && m1_ack));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (grant cycle + fixed latency).
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_mask, m1_mask;
    logic        m0_ack, m0_stall, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_read_data;
    logic        mem_memread, mem_memwrite, mem_clk_stall;
    logic [3:0]  mem_sign_mask;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic        stall_en = 1'b1;
    logic        rd_override_en = 1'b0;
    logic [31:0] rd_override = 32'h0;
    logic        rd_prev;
    logic [136:0] all_outs;

    assign all_outs = {m0_ack, m0_stall, m1_ack, mem_memread, mem_memwrite, mem_addr,
                       mem_wdata, mem_sign_mask, m0_rdata, m1_rdata};

    data_mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .m0_req        (m0_req),
        .m0_we         (m0_we),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_mask       (m0_mask),
        .m0_ack        (m0_ack),
        .m0_rdata      (m0_rdata),
        .m0_stall      (m0_stall),
        .m1_req        (m1_req),
        .m1_we         (m1_we),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_mask       (m1_mask),
        .m1_ack        (m1_ack),
        .m1_rdata      (m1_rdata),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_memread   (mem_memread),
        .mem_memwrite  (mem_memwrite),
        .mem_sign_mask (mem_sign_mask),
        .mem_read_data (mem_read_data),
        .mem_clk_stall (mem_clk_stall)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory model: stalls in the cycle after a read strobe, returns mem_fn(addr).
    initial begin
        mem_clk_stall = 1'b0;
        mem_read_data = 32'h0;
        rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            rd_prev = mem_memread;
            @(posedge clk);
            #1;
            mem_clk_stall = stall_en & rd_prev;
            mem_read_data = rd_override_en ? rd_override : mem_fn(mem_addr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failed=%0d", tests_failed);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_mask = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_mask = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        stall_en = 1'b1;
        rd_override_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #1;
        tests_run++;
        if (all_outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h want 0", all_outs);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({all_outs, dut.protocol_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: got %h want 0", {all_outs, dut.protocol_err});
        end
    endtask

    task automatic test_m0_read();
        rd_override_en = 1'b1;
        rd_override = 32'hDEAD_BEEF;
        cyc();
        m0_req = 1; m0_we = 0; m0_addr = 32'h1004; m0_mask = 4'b0010; m0_wdata = $urandom;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            tests_run++;
            if ({mem_memread, mem_memwrite, m0_ack, m1_ack, m0_stall} !==
                {c == 1, 1'b0, c == 3, 1'b0, c < 3}) begin
                tests_failed++;
                $display("FAIL m0_read_ctl c%0d: got rd/wr/a0/a1/st=%b%b%b%b%b want %b0%b0%b",
                         c, mem_memread, mem_memwrite, m0_ack, m1_ack, m0_stall,
                         c == 1, c == 3, c < 3);
            end
            if (c == 1) begin
                tests_run++;
                if (mem_addr !== 32'h1004 || mem_sign_mask !== 4'b0010) begin
                    tests_failed++;
                    $display("FAIL m0_read_addr: got %h/%b want 00001004/0010",
                             mem_addr, mem_sign_mask);
                end
            end
            if (c == 3) begin
                tests_run++;
                if (m0_rdata !== 32'hDEAD_BEEF) begin
                    tests_failed++;
                    $display("FAIL m0_read_data: got %h want deadbeef", m0_rdata);
                end
                m0_req = 0;
            end
        end
        rd_override_en = 1'b0;
    endtask

    task automatic test_m1_write();
        cyc();
        m1_req = 1; m1_we = 1; m1_addr = 32'h2000; m1_wdata = 32'hA5; m1_mask = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            tests_run++;
            if ({mem_memread, mem_memwrite, m0_ack, m1_ack} !== {1'b0, c == 1, 1'b0, c == 2})
            begin
                tests_failed++;
                $display("FAIL m1_write_ctl c%0d: got rd/wr/a0/a1=%b%b%b%b want 0%b0%b",
                         c, mem_memread, mem_memwrite, m0_ack, m1_ack, c == 1, c == 2);
            end
            if (c == 1) begin
                tests_run++;
                if (mem_addr !== 32'h2000 || mem_wdata !== 32'hA5) begin
                    tests_failed++;
                    $display("FAIL m1_write_bus: got %h/%h want 00002000/000000a5",
                             mem_addr, mem_wdata);
                end
            end
            if (c == 2) m1_req = 0;
        end
    endtask

    task automatic test_tie();
        logic [31:0] a0, a1, exp0, exp1;
        do_reset();
        exp0 = 0;
        exp1 = 0;
        for (int r = 0; r < 2; r++) begin
            a0 = $urandom;
            a1 = $urandom;
            cyc();
            m0_req = 1; m0_we = 0; m0_addr = a0;
            m1_req = 1; m1_we = 0; m1_addr = a1;
            for (int c = 0; c < 9; c++) begin
                if (c > 0) cyc();
                @(negedge clk);
                tests_run++;
                if ({m0_ack, m1_ack} !== {c == 3, c == 7}) begin
                    tests_failed++;
                    $display("FAIL tie_order r%0d c%0d: got a0/a1=%b%b want %b%b",
                             r, c, m0_ack, m1_ack, c == 3, c == 7);
                end
                if (c == 3) begin
                    exp0 = mem_fn(a0);
                    m0_req = 0;
                end
                if (c == 7) begin
                    exp1 = mem_fn(a1);
                    m1_req = 0;
                end
                if (c == 3 || c == 7) begin
                    tests_run++;
                    if (m0_rdata !== exp0 || m1_rdata !== exp1) begin
                        tests_failed++;
                        $display("FAIL tie_rdata r%0d c%0d: got %h/%h want %h/%h",
                                 r, c, m0_rdata, m1_rdata, exp0, exp1);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a0, a1;
        int acks, last_c, id, exp_id;
        do_reset();
        a0 = $urandom;
        a1 = $urandom;
        cyc();
        m0_req = 1; m0_we = 0; m0_addr = a0;
        m1_req = 1; m1_we = 0; m1_addr = a1;
        acks = 0;
        last_c = 0;
        for (int c = 0; c < 80 && acks < 8; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                id = m1_ack ? 1 : 0;
`ifdef DATA_MEM_ARBITER_FIXED_PRIO_EN
                exp_id = 0;
`else
                exp_id = acks % 2;
`endif
                tests_run++;
                if (m0_ack === m1_ack || id != exp_id ||
                    (id == 0 && m0_rdata !== mem_fn(a0)) ||
                    (id == 1 && m1_rdata !== mem_fn(a1))) begin
                    tests_failed++;
                    $display("FAIL b2b_grant #%0d: got a0/a1=%b%b want master %0d",
                             acks, m0_ack, m1_ack, exp_id);
                end
                if (acks > 0) begin
                    tests_run++;
                    if (c - last_c != 4) begin
                        tests_failed++;
                        $display("FAIL b2b_spacing #%0d: got %0d cycles want 4",
                                 acks, c - last_c);
                    end
                end
                last_c = c;
                acks++;
            end
        end
        tests_run++;
        if (acks != 8) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d acks want 8", acks);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        do_reset();
        cyc();
        m0_req = 1; m0_we = 0; m0_addr = $urandom;
        cyc();
        cyc();
        rst = 1'b1;
        idle_inputs();
        #1;
        tests_run++;
        if (all_outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got %h want 0", all_outs);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        a = $urandom;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) cyc();
            if (c == 3) begin
                m1_req = 1; m1_we = 0; m1_addr = a;
            end
            @(negedge clk);
            tests_run++;
            if ({m0_ack, m1_ack} !== {1'b0, c == 6}) begin
                tests_failed++;
                $display("FAIL reset_mid_ack c%0d: got a0/a1=%b%b want 0%b",
                         c, m0_ack, m1_ack, c == 6);
            end
            if (c == 6) begin
                tests_run++;
                if (m1_rdata !== mem_fn(a) || m0_rdata !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL reset_mid_rdata: got %h/%h want 00000000/%h",
                             m0_rdata, m1_rdata, mem_fn(a));
                end
                m1_req = 0;
            end
        end
    endtask

    task automatic test_protocol_err();
        do_reset();
        stall_en = 1'b0;
        cyc();
        m0_req = 1; m0_we = 0; m0_addr = $urandom;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            tests_run++;
            if ({m0_ack, dut.protocol_err} !== {c == 3, c >= 3}) begin
                tests_failed++;
                $display("FAIL protocol_err c%0d: got ack/err=%b%b want %b%b",
                         c, m0_ack, dut.protocol_err, c == 3, c >= 3);
            end
            if (c == 3) begin
                m0_req = 0;
                stall_en = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        bit          req_v[2], fw[2], ack_prev[2], ea[2];
        logic [31:0] fa[2], fd[2], exp_r[2];
        logic [3:0]  fk[2];
        int          left[2];
        bit          busy, last, cur_id, cur_we, er, ew;
        int          g, done, c;
        logic [31:0] cur_addr, cur_wdata, x_addr, x_wdata;
        logic [3:0]  cur_mask, x_mask;
        do_reset();
        for (int m = 0; m < 2; m++) begin
            req_v[m] = 0; fw[m] = 0; fa[m] = 0; fd[m] = 0; fk[m] = 0;
            ack_prev[m] = 0; exp_r[m] = 0; left[m] = 40;
        end
        busy = 0; last = 1; cur_id = 0; cur_we = 0; g = 0; done = 0;
        cur_addr = 0; cur_wdata = 0; cur_mask = 0;
        x_addr = 0; x_wdata = 0; x_mask = 0;
        c = 0;
        while ((left[0] > 0 || left[1] > 0 || busy) && c < 3000) begin
            cyc();
            for (int m = 0; m < 2; m++) begin
                if (ack_prev[m]) begin
                    left[m]--;
                    req_v[m] = (left[m] > 0) && ($urandom_range(1, 0) == 1);
                end else if (!req_v[m] && left[m] > 0) begin
                    req_v[m] = ($urandom_range(2, 0) == 0);
                end
                // New request, idle fields, or post-grant scramble (must be ignored).
                if ((req_v[m] && (ack_prev[m] || !busy || cur_id != m)) || !req_v[m] ||
                    (busy && cur_id == m && c > g)) begin
                    if (!(req_v[m] && !ack_prev[m] && !(busy && cur_id == m && c > g) &&
                          c > 0 && busy && cur_id != m)) begin
                        fw[m] = $urandom_range(1, 0);
                        fa[m] = $urandom;
                        fd[m] = $urandom;
                        fk[m] = 4'($urandom);
                    end
                end
            end
            m0_req = req_v[0]; m0_we = fw[0]; m0_addr = fa[0]; m0_wdata = fd[0];
            m0_mask = fk[0];
            m1_req = req_v[1]; m1_we = fw[1]; m1_addr = fa[1]; m1_wdata = fd[1];
            m1_mask = fk[1];
            if (!busy && (req_v[0] || req_v[1])) begin
`ifdef DATA_MEM_ARBITER_FIXED_PRIO_EN
                cur_id = req_v[0] ? 1'b0 : 1'b1;
`else
                cur_id = (req_v[0] && req_v[1]) ? !last : req_v[1];
                last = cur_id;
`endif
                cur_we = fw[cur_id]; cur_addr = fa[cur_id]; cur_wdata = fd[cur_id];
                cur_mask = fk[cur_id];
                g = c;
                done = c + (cur_we ? 2 : 3);
                busy = 1;
            end
            er = busy && c == g + 1 && !cur_we;
            ew = busy && c == g + 1 && cur_we;
            if (busy && c == g + 1) begin
                x_addr = cur_addr; x_wdata = cur_wdata; x_mask = cur_mask;
            end
            for (int m = 0; m < 2; m++) ea[m] = busy && c == done && cur_id == m;
            if (busy && c == done && !cur_we) exp_r[cur_id] = mem_fn(cur_addr);
            @(negedge clk);
            tests_run++;
            if ({mem_memread, mem_memwrite, m0_ack, m1_ack, m0_stall} !==
                {er, ew, ea[0], ea[1], req_v[0] && !ea[0]}) begin
                tests_failed++;
                $display("FAIL rand_ctl c%0d: got rd/wr/a0/a1/st=%b%b%b%b%b want %b%b%b%b%b",
                         c, mem_memread, mem_memwrite, m0_ack, m1_ack, m0_stall,
                         er, ew, ea[0], ea[1], req_v[0] && !ea[0]);
            end
            tests_run++;
            if ({mem_addr, mem_wdata, mem_sign_mask} !== {x_addr, x_wdata, x_mask}) begin
                tests_failed++;
                $display("FAIL rand_bus c%0d: got %h/%h/%h want %h/%h/%h", c, mem_addr,
                         mem_wdata, mem_sign_mask, x_addr, x_wdata, x_mask);
            end
            tests_run++;
            if (m0_rdata !== exp_r[0] || m1_rdata !== exp_r[1]) begin
                tests_failed++;
                $display("FAIL rand_rdata c%0d: got %h/%h want %h/%h", c, m0_rdata,
                         m1_rdata, exp_r[0], exp_r[1]);
            end
            for (int m = 0; m < 2; m++) ack_prev[m] = ea[m];
            if (busy && c == done) busy = 0;
            c++;
        end
        tests_run++;
        if (left[0] > 0 || left[1] > 0 || busy || dut.protocol_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_complete: got left=%0d/%0d busy=%0d err=%b want 0/0/0/0",
                     left[0], left[1], busy, dut.protocol_err);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_m0_read();
        test_m1_write();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_protocol_err();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
